// File: rtl/fpio_fifo_arb_pkg.sv
// Shared types and helpers for the fpio_fifo write-side arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fpio_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Widest requester vector the helpers below support.
  localparam int MAX_REQ = 16;

  // A burst may cover the whole FIFO, so the length field needs one bit
  // more than the FIFO address.
  function automatic int len_bits_for_depth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // OR-reduction encoder; valid for one-hot or all-zero inputs.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fpio_rr_pick.sv
// Round-robin picker: first set bit of eligible after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; valid simply follows |eligible.
// Ports: eligible (request mask), rr_ptr (last winner) -> valid, pick (index).
module fpio_rr_pick
  import fpio_fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    rr_ptr,
  output logic             valid,
  output logic [IW-1:0]    pick
);

  // Scan from the far end back towards rr_ptr+1 so that the last match
  // written is the one closest after rr_ptr, i.e. the highest priority.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (eligible[(int'(rr_ptr) + k) % N_REQ]) begin
        valid = 1'b1;
        pick  = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fpio_fifo_wr_arb.sv
// Shares one fpio_fifo write port among N_REQ producers, granting whole bursts round-robin.
// Latency: 1 cycle req->gnt; beat data/strobe pass to the FIFO combinationally.
// Backpressure: a burst is granted only if fifo_avail covers all of it; producers may idle mid-burst.
// Ports: clk, rst (sync, active-high); req/req_len/req_data_en/req_data per producer;
//        gnt/gnt_done per producer; fifo_avail in, fifo_data_en/fifo_data out; err sticky flags.
module fpio_fifo_wr_arb
  import fpio_fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_BITS  = 4,
  parameter int LEN_BITS   = len_bits_for_depth(2**FIFO_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*LEN_BITS-1:0]   req_len,
  input  logic [N_REQ-1:0]            req_data_en,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            gnt_done,
  input  logic [FIFO_BITS:0]          fifo_avail,
  output logic                        fifo_data_en,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic [1:0]                  err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Common width for comparing lengths against avail and depth.
  localparam int CW = (LEN_BITS > FIFO_BITS + 1) ? LEN_BITS : FIFO_BITS + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**FIFO_BITS);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]          err_q, err_d;

  logic [CW-1:0]       len_ext [N_REQ];
  logic [CW-1:0]       avail_ext;
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    len_bad;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       gnt_idx;
  logic                beat;
  logic                last_beat;

  assign avail_ext = CW'(fifo_avail);

  // Zero and over-depth lengths can never complete, so they are excluded
  // from arbitration rather than left to wedge the FIFO.
  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_ext[g]  = CW'(req_len[g*LEN_BITS +: LEN_BITS]);
    assign len_bad[g]  = req[g] && ((len_ext[g] == '0) || (len_ext[g] > DEPTH));
    assign eligible[g] = req[g] && !len_bad[g] && (len_ext[g] <= avail_ext);
  end

  fpio_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .valid    (pick_vld),
    .pick     (pick_idx)
  );

  assign gnt_idx   = IW'(onehot_to_idx(MAX_REQ'(gnt_q)));
  // Strobes from producers without a grant are masked here, so they are
  // dropped before reaching the FIFO.
  assign beat      = (state_q == BURST) && |(gnt_q & req_data_en);
  assign last_beat = beat && (beat_cnt_q == LEN_BITS'(1));

  assign fifo_data_en = beat && !rst;
  assign fifo_data    = ((state_q == BURST) && !rst)
                        ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign gnt_done     = (last_beat && !rst) ? gnt_q : '0;
  assign gnt          = rst ? '0 : gnt_q;
  assign err          = rst ? 2'b00 : err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q;

    if (|(req_data_en & ~gnt_q)) err_d[0] = 1'b1;

    case (state_q)
      IDLE: begin
        if (|len_bad) err_d[1] = 1'b1;
        if (pick_vld) begin
          gnt_d      = N_REQ'(1) << pick_idx;
          beat_cnt_d = req_len[pick_idx*LEN_BITS +: LEN_BITS];
          rr_ptr_d   = pick_idx;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Length was latched at grant; req and req_len are ignored here.
        if (beat) begin
          if (beat_cnt_q == LEN_BITS'(1)) begin
            gnt_d      = '0;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - LEN_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpio_fifo_wr_arb.sv
module tb_fpio_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FB = 4;
  localparam int LB = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*LB-1:0] req_len;
  logic [N-1:0]    req_data_en;
  logic [N*DW-1:0] req_data;
  logic [FB:0]     fifo_avail;
  logic [N-1:0]    gnt;
  logic [N-1:0]    gnt_done;
  logic            fifo_data_en;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      err;

  int checks   = 0;
  int failures = 0;

  fpio_fifo_wr_arb #(
    .N_REQ(N), .DATA_WIDTH(DW), .FIFO_BITS(FB), .LEN_BITS(LB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .req_data_en(req_data_en), .req_data(req_data),
    .gnt(gnt), .gnt_done(gnt_done), .fifo_avail(fifo_avail),
    .fifo_data_en(fifo_data_en), .fifo_data(fifo_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*LB-1:0] lens;
    logic [FB:0]     avail;
    logic [N-1:0]    den;
    logic [N-1:0]    exp_gnt;
    logic [1:0]      exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LB +: LB] = LB'(v);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  function automatic int len_of(input int i);
    return int'(req_len[i*LB +: LB]);
  endfunction

  task automatic clear_inputs();
    req = '0; req_len = '0; req_data_en = '0; req_data = '0; fifo_avail = 5'd16;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Sample at the falling edge, then move to just after the next rising edge.
  task automatic cyc(input string nm, input logic [N-1:0] eg, input logic ee,
                     input logic [DW-1:0] ed, input logic [N-1:0] edn);
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(gnt), 64'(eg));
    chk({nm, "_en"}, 64'(fifo_data_en), 64'(ee));
    if (ee) chk({nm, "_data"}, 64'(fifo_data), 64'(ed));
    chk({nm, "_done"}, 64'(gnt_done), 64'(edn));
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, rem, ptr, occ, r, idx;
    logic [1:0]   merr;
    logic [N-1:0] drop, eg, edn;
    logic         ee;
    logic [DW-1:0] ed;

    // Table: {req, lens {l3,l2,l1,l0}, avail, data_en, expected gnt, expected err}
    tbl[0]  = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd4},  5'd16, 4'b0000, 4'b0001, 2'b00};
    tbl[1]  = '{4'b0101, {5'd0, 5'd3, 5'd0, 5'd4},  5'd3,  4'b0000, 4'b0100, 2'b00};
    tbl[2]  = '{4'b1000, {5'd0, 5'd0, 5'd0, 5'd0},  5'd16, 4'b0000, 4'b0000, 2'b10};
    tbl[3]  = '{4'b1000, {5'd17, 5'd0, 5'd0, 5'd0}, 5'd16, 4'b0000, 4'b0000, 2'b10};
    tbl[4]  = '{4'b0010, {5'd0, 5'd0, 5'd16, 5'd0}, 5'd16, 4'b0000, 4'b0010, 2'b00};
    tbl[5]  = '{4'b0010, {5'd0, 5'd0, 5'd16, 5'd0}, 5'd15, 4'b0000, 4'b0000, 2'b00};
    tbl[6]  = '{4'b1110, {5'd2, 5'd2, 5'd2, 5'd0},  5'd16, 4'b0000, 4'b0010, 2'b00};
    tbl[7]  = '{4'b1111, {5'd4, 5'd4, 5'd5, 5'd17}, 5'd4,  4'b0000, 4'b0100, 2'b10};
    tbl[8]  = '{4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  5'd16, 4'b0010, 4'b0000, 2'b01};
    tbl[9]  = '{4'b1001, {5'd1, 5'd0, 5'd0, 5'd1},  5'd1,  4'b0000, 4'b0001, 2'b00};
    tbl[10] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},  5'd2,  4'b0000, 4'b0000, 2'b00};
    tbl[11] = '{4'b0011, {5'd0, 5'd0, 5'd2, 5'd3},  5'd2,  4'b0001, 4'b0010, 2'b01};

    // Reset state: outputs held at zero even with active inputs.
    rst = 1'b1;
    req = 4'b1111; req_len = {5'd2, 5'd2, 5'd2, 5'd2}; req_data_en = 4'b1111;
    req_data = {4{32'hDEADBEEF}}; fifo_avail = 5'd16;
    step();
    step();
    @(negedge clk);
    chk("RST_gnt", 64'(gnt), 64'd0);
    chk("RST_en", 64'(fifo_data_en), 64'd0);
    chk("RST_data", 64'(fifo_data), 64'd0);
    chk("RST_done", 64'(gnt_done), 64'd0);
    chk("RST_err", 64'(err), 64'd0);
    step();

    // Table-driven single-arbitration vectors, each from a fresh reset.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      req = tbl[t].req; req_len = tbl[t].lens;
      fifo_avail = tbl[t].avail; req_data_en = tbl[t].den;
      @(negedge clk);
      chk($sformatf("T%0d_idle_en", t), 64'(fifo_data_en), 64'd0);
      step();
      req_data_en = '0;
      @(negedge clk);
      chk($sformatf("T%0d_gnt", t), 64'(gnt), 64'(tbl[t].exp_gnt));
      chk($sformatf("T%0d_err", t), 64'(err), 64'(tbl[t].exp_err));
      step();
    end

    // A: single 4-beat burst from producer 0.
    do_reset();
    set_len(0, 4); req = 4'b0001;
    cyc("A_arb", 4'b0000, 1'b0, '0, 4'b0000);
    for (int b = 1; b <= 4; b++) begin
      req_data_en = 4'b0001;
      set_data(0, 32'hA000_0000 + 32'(b));
      cyc("A_beat", 4'b0001, 1'b1, 32'hA000_0000 + 32'(b), (b == 4) ? 4'b0001 : 4'b0000);
    end
    req = '0; req_data_en = '0;
    cyc("A_after", 4'b0000, 1'b0, '0, 4'b0000);
    @(negedge clk); chk("A_err", 64'(err), 64'd0); step();

    // B: all four request len 2 continuously; order 0,1,2,3,0 with one idle gap.
    do_reset();
    req_len = {5'd2, 5'd2, 5'd2, 5'd2}; req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      req_data_en = gnt;
      for (int i = 0; i < N; i++) set_data(i, 32'hB000_0000 + 32'(i * 256 + c));
      eg = (c % 3 == 0) ? 4'b0000 : 4'(4'b0001 << ((c / 3) % 4));
      @(negedge clk);
      chk($sformatf("B_gnt_c%0d", c), 64'(gnt), 64'(eg));
      chk($sformatf("B_done_c%0d", c), 64'(gnt_done), 64'((c % 3 == 2) ? eg : 4'b0000));
      step();
    end
    @(negedge clk); chk("B_err", 64'(err), 64'd0); step();

    // C: small burst bypasses a large one that does not fit; large one follows later.
    do_reset();
    fifo_avail = 5'd3; set_len(0, 4); set_len(2, 3); req = 4'b0101;
    cyc("C_arb", 4'b0000, 1'b0, '0, 4'b0000);
    for (int b = 1; b <= 3; b++) begin
      req_data_en = 4'b0100; set_data(2, 32'hC200_0000 + 32'(b));
      cyc("C_small", 4'b0100, 1'b1, 32'hC200_0000 + 32'(b), (b == 3) ? 4'b0100 : 4'b0000);
    end
    req = 4'b0001; req_data_en = '0; fifo_avail = 5'd8;
    cyc("C_idle", 4'b0000, 1'b0, '0, 4'b0000);
    for (int b = 1; b <= 4; b++) begin
      req_data_en = 4'b0001; set_data(0, 32'hC000_0000 + 32'(b));
      cyc("C_big", 4'b0001, 1'b1, 32'hC000_0000 + 32'(b), (b == 4) ? 4'b0001 : 4'b0000);
    end
    req = '0; req_data_en = '0;
    @(negedge clk); chk("C_err", 64'(err), 64'd0); step();

    // D: producer stalls for 5 cycles mid-burst.
    do_reset();
    set_len(1, 3); req = 4'b0010;
    cyc("D_arb", 4'b0000, 1'b0, '0, 4'b0000);
    req_data_en = 4'b0010; set_data(1, 32'hD000_0001);
    cyc("D_b1", 4'b0010, 1'b1, 32'hD000_0001, 4'b0000);
    req_data_en = '0;
    for (int s = 0; s < 5; s++) cyc("D_stall", 4'b0010, 1'b0, '0, 4'b0000);
    req_data_en = 4'b0010; set_data(1, 32'hD000_0002);
    cyc("D_b2", 4'b0010, 1'b1, 32'hD000_0002, 4'b0000);
    set_data(1, 32'hD000_0003);
    cyc("D_b3", 4'b0010, 1'b1, 32'hD000_0003, 4'b0010);
    req = '0; req_data_en = '0;
    cyc("D_end", 4'b0000, 1'b0, '0, 4'b0000);

    // E: stray strobe and illegal length, both sticky.
    do_reset();
    req_data_en = 4'b0010; set_data(1, 32'hEEEE_0001);
    @(negedge clk); chk("E_stray_en", 64'(fifo_data_en), 64'd0); step();
    req_data_en = '0; set_len(3, 17); req = 4'b1000;
    for (int s = 0; s < 4; s++) cyc("E_len17", 4'b0000, 1'b0, '0, 4'b0000);
    @(negedge clk); chk("E_err_both", 64'(err), 64'd3); step();
    req = '0;
    step(); step();
    @(negedge clk); chk("E_err_sticky", 64'(err), 64'd3); step();

    // F: reset during beat 2 of a 4-beat burst from producer 2.
    do_reset();
    set_len(2, 4); req = 4'b0100;
    cyc("F_arb", 4'b0000, 1'b0, '0, 4'b0000);
    req_data_en = 4'b0100; set_data(2, 32'hF000_0001);
    cyc("F_b1", 4'b0100, 1'b1, 32'hF000_0001, 4'b0000);
    rst = 1'b1; set_data(2, 32'hF000_0002);
    @(negedge clk);
    chk("F_rst_done", 64'(gnt_done), 64'd0);
    chk("F_rst_en", 64'(fifo_data_en), 64'd0);
    step();
    rst = 1'b0; req_data_en = '0; set_len(0, 2); set_len(3, 2); req = 4'b1001;
    @(negedge clk);
    chk("F_post_gnt", 64'(gnt), 64'd0);
    chk("F_post_err", 64'(err), 64'd0);
    step();
    @(negedge clk); chk("F_regrant", 64'(gnt), 64'b0001); step();

    // Random traffic against a burst-level reference model.
    do_reset();
    act = -1; rem = 0; ptr = N - 1; merr = 2'b00; occ = 0; drop = '0;
    for (int cy = 0; cy < 3000; cy++) begin
      req = req & ~drop;
      if (occ > 0 && $urandom_range(0, 2) != 0) occ--;
      fifo_avail = 5'(16 - occ);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            r = int'($urandom_range(0, 39));
            set_len(i, (r == 0) ? 0 : (r == 1) ? 17 : (r < 5) ? 16 : int'($urandom_range(1, 8)));
          end
        end else if (act != i && (len_of(i) == 0 || len_of(i) > 16) && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
        req_data_en[i] = (act == i) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 299) == 0);
        set_data(i, $urandom);
      end

      eg  = (act >= 0) ? 4'(1 << act) : 4'b0000;
      ee  = (act >= 0) ? req_data_en[act] : 1'b0;
      ed  = ee ? req_data[act*DW +: DW] : '0;
      edn = (ee && rem == 1) ? eg : 4'b0000;

      @(negedge clk);
      chk("R_gnt", 64'(gnt), 64'(eg));
      chk("R_en", 64'(fifo_data_en), 64'(ee));
      if (ee) chk("R_data", 64'(fifo_data), 64'(ed));
      chk("R_done", 64'(gnt_done), 64'(edn));
      chk("R_err", 64'(err), 64'(merr));
      if (fifo_data_en) occ++;
      chk("R_no_overflow", 64'(occ <= 16), 64'd1);

      drop = edn;
      for (int i = 0; i < N; i++) if (req_data_en[i] && act != i) merr[0] = 1'b1;
      if (act < 0) begin
        for (int i = 0; i < N; i++)
          if (req[i] && (len_of(i) == 0 || len_of(i) > 16)) merr[1] = 1'b1;
        for (int k = 1; k <= N; k++) begin
          idx = (ptr + k) % N;
          if (act < 0 && req[idx] && len_of(idx) >= 1 && len_of(idx) <= 16 &&
              len_of(idx) <= int'(fifo_avail)) begin
            act = idx; rem = len_of(idx); ptr = idx;
          end
        end
      end else if (req_data_en[act]) begin
        rem--;
        if (rem == 0) act = -1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
